bp_fe_bht_port_arbiter: RTL and testbench
=========================================

# bp_fe_bht_port_arbiter

Controller that shares the single access port of the front-end local two-level branch predictor between fetch-time prediction reads and backend branch-resolution updates. Resolution updates are buffered in a small FIFO and issued to the predictor whenever fetch leaves the port idle. A starvation counter and a FIFO-full condition force an update through by stalling fetch for one cycle. The block sits between the fetch PC stage, the backend commit/redirect path and the predictor table.

## Interface
- bht_idx_width_p, 9, predictor index width
- fifo_els_p, 4, update FIFO depth; power of two, ≥2
- starve_limit_p, 8, consecutive denied-update cycles before a forced write; ≥1
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- upd_v_i  in  1  update valid (valid/ready handshake)
- upd_ready_o  out  1  FIFO can accept an update
- upd_idx_i  in  bht_idx_width_p  index of the resolved branch
- upd_correct_i  in  1  prediction was correct
- flush_i  in  1  discard all queued updates
- fetch_v_i  in  1  fetch requests a prediction this cycle
- fetch_idx_i  in  bht_idx_width_p  fetch lookup index
- fetch_ready_o  out  1  fetch read granted this cycle
- bp_r_v_o  out  1  predictor read valid
- bp_w_v_o  out  1  predictor write valid
- bp_idx_r_o  out  bht_idx_width_p  predictor read index (= fetch_idx_i)
- bp_idx_w_o  out  bht_idx_width_p  predictor write index (FIFO head)
- bp_correct_o  out  1  FIFO head correct bit

## Operation
- FIFO: circular, pointers with wrap bit, count 0..fifo_els_p. Push on upd_v_i & upd_ready_o. Pop on bp_w_v_o.
- upd_ready_o = ~full. Registered-state only; a same-cycle pop does not raise it.
- FSM has two states: RUN and FORCE.
- RUN:
  - fetch_ready_o = 1; bp_r_v_o = fetch_v_i.
  - bp_w_v_o = ~empty & ~fetch_v_i.
- FORCE:
  - fetch_ready_o = 0; bp_r_v_o = 0.
  - bp_w_v_o = ~empty.
  - Always returns to RUN next cycle.
- Starvation counter (width clog2(starve_limit_p+1)):
  - Increments each RUN cycle with ~empty & fetch_v_i (update denied).
  - Clears on any write, when empty, and on flush.
- RUN→FORCE next cycle when either:
  - counter reaches starve_limit_p on this cycle's increment, or
  - FIFO is full and the write is denied this cycle.
- flush_i:
  - Next cycle: count=0, pointers reset, counter=0, state RUN.
  - Dominates a same-cycle push; the pushed entry is dropped.
  - A same-cycle write still reaches the predictor.
- Simultaneous push and pop: count unchanged; push into a full FIFO is impossible.
- Same-index read/write in one cycle cannot occur (single port). No hazard forwarding; a read may see a table not yet updated by queued entries.

## Timing
- All grants and bp_* outputs combinational from state and inputs; no added read latency.
- Update latency: minimum 1 cycle from push to bp_w_v_o (entry visible at head the cycle after push).
- Worst-case write delay for the head entry under continuous fetch: starve_limit_p+1 cycles.
- Reset (asynchronous assert, synchronous-release flops): state RUN, FIFO empty, counter 0.
  - Outputs while in reset: upd_ready_o=1, bp_w_v_o=0, fetch_ready_o=1, bp_r_v_o=fetch_v_i, bp_idx_w_o=0, bp_correct_o=0.
  - Reset mid-operation discards queued updates and any pending FORCE.

## Configuration
- BP_UPD_BYPASS_EN:
  - Defined: in RUN with FIFO empty, ~fetch_v_i and upd_v_i, the update drives bp_w_v_o/bp_idx_w_o/bp_correct_o directly in the same cycle and is not enqueued (0-cycle latency).
  - Undefined: every update passes through the FIFO.

## Test plan
- Reset, no fetch: push idx=5, correct=1 → next cycle bp_w_v_o=1, bp_idx_w_o=5, bp_correct_o=1; FIFO empty after.
- Continuous fetch_v_i=1, one queued update, starve_limit_p=8 → 8 RUN cycles with bp_w_v_o=0, then one FORCE cycle: fetch_ready_o=0, bp_w_v_o=1; RUN resumes.
- Continuous fetch, push 4 updates → upd_ready_o=0 after the 4th; FORCE the next cycle; upd_ready_o=1 the cycle after the pop.
- 3 queued, flush_i and upd_v_i together → next cycle FIFO empty, upd_ready_o=1, bp_w_v_o=0, pushed entry absent.
- reset_n_i pulsed low mid-FORCE with 2 queued → immediately bp_w_v_o=0, fetch_ready_o=1; after release, no stale writes issued.
- BP_UPD_BYPASS_EN defined, empty FIFO, idle fetch, push idx=9 → bp_w_v_o=1, bp_idx_w_o=9 in the same cycle; FIFO count stays 0.

Source files
------------

// File: rtl/bp_fe_bht_port_arbiter.sv
// Arbitrates the single BHT port between fetch prediction reads and queued resolution updates.
// Optional macro BP_UPD_BYPASS_EN lets an update write straight through when the port and FIFO are idle.
`timescale 1ns/1ps
module bp_fe_bht_port_arbiter #(
  parameter int bht_idx_width_p = 9,
  parameter int fifo_els_p      = 4,
  parameter int starve_limit_p  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       upd_v_i,
  output logic                       upd_ready_o,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  input  logic                       flush_i,
  input  logic                       fetch_v_i,
  input  logic [bht_idx_width_p-1:0] fetch_idx_i,
  output logic                       fetch_ready_o,
  output logic                       bp_r_v_o,
  output logic                       bp_w_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_r_o,
  output logic [bht_idx_width_p-1:0] bp_idx_w_o,
  output logic                       bp_correct_o,
  output logic [0:0]                 dbg_state_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FORCE = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [ptr_w_lp:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [bht_idx_width_p:0]  mem_q [fifo_els_p];
  logic [bht_idx_width_p:0]  head;

  logic is_run, empty, full, fifo_w_v, bypass_v, push, pop, deny;
  logic starve_hit, full_hit;

  assign is_run = (state_q == ST_RUN);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]) &&
                  (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0]);
  assign head   = mem_q[rd_ptr_q[ptr_w_lp-1:0]];

`ifdef BP_UPD_BYPASS_EN
  assign bypass_v = is_run & empty & ~fetch_v_i & upd_v_i;
`else
  assign bypass_v = 1'b0;
`endif

  // Update handshake: an update transfers on a cycle where upd_v_i & upd_ready_o;
  // upd_ready_o depends only on registered occupancy, never on a same-cycle pop.
  assign upd_ready_o   = ~full;
  assign fetch_ready_o = is_run;
  assign bp_r_v_o      = is_run & fetch_v_i;
  assign bp_idx_r_o    = fetch_idx_i;
  assign dbg_state_o   = state_q;

  assign fifo_w_v = is_run ? (~empty & ~fetch_v_i) : ~empty;
  assign bp_w_v_o = fifo_w_v | bypass_v;

  always_comb begin
    bp_idx_w_o   = '0;
    bp_correct_o = 1'b0;
    if (bypass_v) begin
      bp_idx_w_o   = upd_idx_i;
      bp_correct_o = upd_correct_i;
    end else if (!empty) begin
      bp_idx_w_o   = head[bht_idx_width_p-1:0];
      bp_correct_o = head[bht_idx_width_p];
    end
  end

  assign push    = upd_v_i & upd_ready_o & ~bypass_v & ~flush_i;
  assign pop     = fifo_w_v;
  assign deny    = is_run & ~empty & fetch_v_i;
  assign cnt_inc = cnt_q + cnt_w_lp'(1);

  assign starve_hit = deny & (cnt_inc == cnt_w_lp'(starve_limit_p));
  assign full_hit   = deny & full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    state_d  = ST_RUN;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (ptr_w_lp+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (ptr_w_lp+1)'(1);
      if (pop || empty) cnt_d = '0;
      else if (deny)    cnt_d = cnt_inc;
      // FORCE is a single stolen fetch cycle; it never chains.
      if (starve_hit || full_hit) state_d = ST_FORCE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= {upd_correct_i, upd_idx_i};
  end

endmodule

// File: tb/tb_bp_fe_bht_port_arbiter.sv
// Directed bench for bp_fe_bht_port_arbiter: reset, drain, starvation, full, flush, mid-FORCE reset.
`timescale 1ns/1ps
module tb_bp_fe_bht_port_arbiter;
  localparam int W = 9;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         upd_v_i, upd_ready_o, upd_correct_i, flush_i;
  logic [W-1:0] upd_idx_i, fetch_idx_i, bp_idx_r_o, bp_idx_w_o;
  logic         fetch_v_i, fetch_ready_o, bp_r_v_o, bp_w_v_o, bp_correct_o;
  logic [0:0]   dbg_state_o;

  logic [W:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  bit found;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  bp_fe_bht_port_arbiter #(.bht_idx_width_p(W), .fifo_els_p(4), .starve_limit_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .upd_v_i(upd_v_i), .upd_ready_o(upd_ready_o), .upd_idx_i(upd_idx_i),
    .upd_correct_i(upd_correct_i), .flush_i(flush_i),
    .fetch_v_i(fetch_v_i), .fetch_idx_i(fetch_idx_i), .fetch_ready_o(fetch_ready_o),
    .bp_r_v_o(bp_r_v_o), .bp_w_v_o(bp_w_v_o), .bp_idx_r_o(bp_idx_r_o),
    .bp_idx_w_o(bp_idx_w_o), .bp_correct_o(bp_correct_o), .dbg_state_o(dbg_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a write is expected now; its payload must match the oldest queued update.
  task automatic expect_write(input string tag);
    logic [W:0] e;
    chk({tag, "_wv"}, bp_w_v_o, 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: write expected but scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_idx"}, bp_idx_w_o, e[W-1:0]);
      chk({tag, "_corr"}, bp_correct_o, e[W]);
    end
  endtask

  // driver tasks
  task automatic next_cyc();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic uv, input logic [W-1:0] idx, input logic corr,
                       input logic fv, input logic fl);
    upd_v_i = uv; upd_idx_i = idx; upd_correct_i = corr;
    fetch_v_i = fv; flush_i = fl;
    if (uv && !fl) exp_q.push_back({corr, idx});
  endtask

  initial begin
    reset_n_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    fetch_idx_i = 9'h1a3;
    #3;
    chk("rst_upd_ready", upd_ready_o, 1);
    chk("rst_wv", bp_w_v_o, 0);
    chk("rst_fetch_ready", fetch_ready_o, 1);
    chk("rst_rv", bp_r_v_o, 1);
    chk("rst_idx_r", bp_idx_r_o, 9'h1a3);
    chk("rst_idx_w", bp_idx_w_o, 0);
    chk("rst_corr", bp_correct_o, 0);
    chk("rst_state", dbg_state_o, 0);

    // single update drains once fetch is idle
    next_cyc();
    reset_n_i = 1'b1;
    drive(1'b1, 9'd5, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef BP_UPD_BYPASS_EN
    expect_write("t1_bypass");
`else
    chk("t1_same_cyc_wv", bp_w_v_o, 0);
`endif
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef BP_UPD_BYPASS_EN
    chk("t1_no_enqueue", bp_w_v_o, 0);
`else
    expect_write("t1_head");
`endif
    next_cyc(); #1;
    chk("t1_drained_wv", bp_w_v_o, 0);
    chk("t1_drained_ready", upd_ready_o, 1);

    // starvation: 8 denied RUN cycles then one FORCE
    next_cyc();
    drive(1'b1, 9'd7, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t2_push_ready", upd_ready_o, 1);
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("t2_starve_wv", bp_w_v_o, 0);
      chk("t2_starve_fready", fetch_ready_o, 1);
    end
    next_cyc(); #1;
    chk("t2_force_state", dbg_state_o, 1);
    chk("t2_force_fready", fetch_ready_o, 0);
    chk("t2_force_rv", bp_r_v_o, 0);
    expect_write("t2_force");
    next_cyc(); #1;
    chk("t2_run_state", dbg_state_o, 0);
    chk("t2_run_fready", fetch_ready_o, 1);
    chk("t2_run_wv", bp_w_v_o, 0);

    // fill the FIFO under continuous fetch
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      drive(1'b1, W'(10 + i), i[0], 1'b1, 1'b0);
      #1;
      chk("t3_fill_ready", upd_ready_o, 1);
    end
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t3_full_ready", upd_ready_o, 0);
    chk("t3_full_wv", bp_w_v_o, 0);
    chk("t3_full_state", dbg_state_o, 0);
    next_cyc(); #1;
    chk("t3_force_state", dbg_state_o, 1);
    expect_write("t3_force");
    chk("t3_force_ready", upd_ready_o, 0);
    next_cyc(); #1;
    chk("t3_after_ready", upd_ready_o, 1);
    chk("t3_after_state", dbg_state_o, 0);
    chk("t3_after_wv", bp_w_v_o, 0);

    // flush with 3 queued and a simultaneous push
    next_cyc();
    drive(1'b1, 9'h55, 1'b1, 1'b0, 1'b1);
    #1;
    expect_write("t4_flush_wr");
    exp_q.delete();
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t4_ready", upd_ready_o, 1);
    chk("t4_wv", bp_w_v_o, 0);
    chk("t4_idx_w", bp_idx_w_o, 0);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); #1;
      chk("t4_no_stale", bp_w_v_o, 0);
    end

    // reset pulse in the middle of a FORCE cycle with 2 queued
    next_cyc();
    drive(1'b1, 9'd20, 1'b1, 1'b1, 1'b0);
    next_cyc();
    drive(1'b1, 9'd21, 1'b0, 1'b1, 1'b0);
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (dbg_state_o == 1'b1) begin
        found = 1'b1;
        break;
      end
      next_cyc();
    end
    chk("t5_force_seen", found, 1);
    reset_n_i = 1'b0;
    #1;
    chk("t5_rst_wv", bp_w_v_o, 0);
    chk("t5_rst_fready", fetch_ready_o, 1);
    chk("t5_rst_rv", bp_r_v_o, 1);
    chk("t5_rst_ready", upd_ready_o, 1);
    chk("t5_rst_state", dbg_state_o, 0);
    exp_q.delete();
    next_cyc();
    reset_n_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t5_rel_wv", bp_w_v_o, 0);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); #1;
      chk("t5_no_stale", bp_w_v_o, 0);
    end

`ifdef BP_UPD_BYPASS_EN
    next_cyc();
    drive(1'b1, 9'd9, 1'b0, 1'b0, 1'b0);
    #1;
    expect_write("t6_bypass");
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t6_count_zero", bp_w_v_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: bench did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
